d_cache_sa: RTL

Parametrised two-way set-associative, write-back, write-allocate data cache with byte-granular stores. It is the next generation of the MIPS CPU data cache. It sits between the memory stage and the burst memory port, and it generalises line size, set count and data width. It adds per-set LRU replacement, byte enables and single-cycle back-to-back hits.

---
 rtl/d_cache_sa.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/d_cache_sa.sv
`default_nettype none
// ============================================================================
// Module   : d_cache_sa
// Brief    : Two-way set-associative, write-back, write-allocate data cache
//            with byte-granular stores, per-set LRU and burst line transfers.
// Revision : 1.0 - initial release
// ============================================================================
module d_cache_sa #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDRESS_WIDTH      = 22,
    parameter int INDEX_WIDTH        = 8,
    parameter int BLOCK_OFFSET_WIDTH = 2
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_Valid,
    input  logic                      i_Read_Write_n,
    input  logic [ADDRESS_WIDTH-1:0]  i_Address,
    input  logic [DATA_WIDTH-1:0]     i_Write_Data,
    input  logic [DATA_WIDTH/8-1:0]   i_Byte_En,
    output logic                      o_Ready,
    output logic                      o_Valid,
    output logic [DATA_WIDTH-1:0]     o_Data,
    output logic                      o_MEM_Valid,
    output logic                      o_MEM_Read_Write_n,
    output logic [ADDRESS_WIDTH-1:0]  o_MEM_Address,
    output logic [DATA_WIDTH-1:0]     o_MEM_Data,
    input  logic                      i_MEM_Valid,
    input  logic                      i_MEM_Data_Read,
    input  logic                      i_MEM_Last,
    input  logic [DATA_WIDTH-1:0]     i_MEM_Data
);
    localparam int TAG_WIDTH     = ADDRESS_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
    localparam int c_BYTES       = DATA_WIDTH / 8;
    localparam int c_SETS        = 1 << INDEX_WIDTH;
    localparam int c_LINE_AW     = INDEX_WIDTH + BLOCK_OFFSET_WIDTH;
    localparam int c_WORDS_TOTAL = 1 << c_LINE_AW;

    typedef enum logic [1:0] {
        S_READY    = 2'd0,
        S_WRITEOUT = 2'd1,
        S_FILL     = 2'd2
    } state_t;

    // Storage: tags and data carry no reset; valid bits qualify them.
    logic [TAG_WIDTH-1:0]  r_tag0  [c_SETS];
    logic [TAG_WIDTH-1:0]  r_tag1  [c_SETS];
    logic [DATA_WIDTH-1:0] r_data0 [c_WORDS_TOTAL];
    logic [DATA_WIDTH-1:0] r_data1 [c_WORDS_TOTAL];
    logic [c_SETS-1:0]     r_valid0, r_valid1, r_dirty0, r_dirty1, r_lru;

    state_t                       r_state;
    logic                         r_Ready, r_Valid, r_MEM_Valid, r_MEM_RW;
    logic [ADDRESS_WIDTH-1:0]     r_MEM_Address;
    logic [DATA_WIDTH-1:0]        r_MEM_Data, r_Data;

    // Captured miss request
    logic                         r_way, r_store;
    logic [INDEX_WIDTH-1:0]       r_idx;
    logic [TAG_WIDTH-1:0]         r_tag;
    logic [BLOCK_OFFSET_WIDTH-1:0] r_off, r_cnt;
    logic [DATA_WIDTH-1:0]        r_wdata;
    logic [c_BYTES-1:0]           r_be;

    logic [TAG_WIDTH-1:0]          w_tag;
    logic [INDEX_WIDTH-1:0]        w_idx;
    logic [BLOCK_OFFSET_WIDTH-1:0] w_off;
    logic                          w_hit0, w_hit1, w_hit, w_accept, w_victim, w_victim_dirty;
    logic [DATA_WIDTH-1:0]         w_hit_word, w_wb_word, w_fill_word;
    logic [TAG_WIDTH-1:0]          w_wb_tag;
    logic                          w_we, w_we_way, w_tag_we;
    logic [c_LINE_AW-1:0]          w_waddr;
    logic [DATA_WIDTH-1:0]         w_wdata;
    logic [c_BYTES-1:0]            w_wbe;

    assign w_tag    = i_Address[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign w_idx    = i_Address[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_off    = i_Address[BLOCK_OFFSET_WIDTH-1:0];
    assign w_hit0   = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
    assign w_hit1   = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
    assign w_hit    = w_hit0 || w_hit1;
    assign w_accept = i_Valid && r_Ready;
    assign w_hit_word = w_hit1 ? r_data1[{w_idx, w_off}] : r_data0[{w_idx, w_off}];

    // Victim: first invalid way, otherwise the way named by the LRU bit.
    assign w_victim       = !r_valid0[w_idx] ? 1'b0 : (!r_valid1[w_idx] ? 1'b1 : r_lru[w_idx]);
    assign w_victim_dirty = w_victim ? (r_valid1[w_idx] && r_dirty1[w_idx])
                                     : (r_valid0[w_idx] && r_dirty0[w_idx]);

    // Writeback source: word r_cnt of the captured victim line.
    assign w_wb_word = r_way ? r_data1[{r_idx, r_cnt}] : r_data0[{r_idx, r_cnt}];
    assign w_wb_tag  = r_way ? r_tag1[r_idx] : r_tag0[r_idx];
    assign w_tag_we  = (r_state == S_FILL) && i_MEM_Valid && i_MEM_Last;

    // Merge the pending store's enabled bytes over the matching fill beat.
    always_comb begin
        w_fill_word = i_MEM_Data;
        for (int b = 0; b < c_BYTES; b++) begin
            if (r_store && (r_cnt == r_off) && r_be[b]) begin
                w_fill_word[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end

    // Single data write port shared by store hits and fill beats.
    always_comb begin
        w_we     = 1'b0;
        w_we_way = 1'b0;
        w_waddr  = {w_idx, w_off};
        w_wdata  = i_Write_Data;
        w_wbe    = i_Byte_En;
        if ((r_state == S_READY) && w_accept && !i_Read_Write_n && w_hit) begin
            w_we     = 1'b1;
            w_we_way = w_hit1;
        end else if ((r_state == S_FILL) && i_MEM_Valid) begin
            w_we     = 1'b1;
            w_we_way = r_way;
            w_waddr  = {r_idx, r_cnt};
            w_wdata  = w_fill_word;
            w_wbe    = '1;
        end
    end

    // Data and tag array updates (byte-lane writes, tag on the last fill beat).
    always_ff @(posedge i_Clk) begin
        if (w_we) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (w_wbe[b]) begin
                    if (w_we_way) r_data1[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
                    else          r_data0[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
        if (w_tag_we) begin
            if (r_way) r_tag1[r_idx] <= r_tag;
            else       r_tag0[r_idx] <= r_tag;
        end
    end

    // Control FSM: lookup, victim writeback, line fill; all outputs registered.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state       <= S_READY;
            r_Ready       <= 1'b1;
            r_Valid       <= 1'b0;
            r_MEM_Valid   <= 1'b0;
            r_MEM_RW      <= 1'b1;
            r_MEM_Address <= '0;
            r_MEM_Data    <= '0;
            r_Data        <= '0;
            r_valid0      <= '0;
            r_valid1      <= '0;
            r_dirty0      <= '0;
            r_dirty1      <= '0;
            r_lru         <= '0;
            r_way         <= 1'b0;
            r_store       <= 1'b0;
            r_idx         <= '0;
            r_tag         <= '0;
            r_off         <= '0;
            r_cnt         <= '0;
            r_wdata       <= '0;
            r_be          <= '0;
        end else begin
            r_Valid <= 1'b0;
            case (r_state)
                S_READY: begin
                    if (w_accept) begin
                        if (w_hit) begin
                            r_Valid       <= 1'b1;
                            r_lru[w_idx]  <= !w_hit1;
                            if (i_Read_Write_n) begin
                                r_Data <= w_hit_word;
                            end else if (w_hit1) begin
                                r_dirty1[w_idx] <= 1'b1;
                            end else begin
                                r_dirty0[w_idx] <= 1'b1;
                            end
                        end else begin
                            r_Ready <= 1'b0;
                            r_way   <= w_victim;
                            r_idx   <= w_idx;
                            r_tag   <= w_tag;
                            r_off   <= w_off;
                            r_store <= !i_Read_Write_n;
                            r_wdata <= i_Write_Data;
                            r_be    <= i_Byte_En;
                            r_cnt   <= '0;
                            if (w_victim_dirty) begin
                                // One cycle to fetch word 0 before the burst opens.
                                r_state <= S_WRITEOUT;
                            end else begin
                                r_state       <= S_FILL;
                                r_MEM_Valid   <= 1'b1;
                                r_MEM_RW      <= 1'b1;
                                r_MEM_Address <= {w_tag, w_idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
                            end
                        end
                    end
                end
                S_WRITEOUT: begin
                    if (!r_MEM_Valid) begin
                        r_MEM_Valid   <= 1'b1;
                        r_MEM_RW      <= 1'b0;
                        r_MEM_Address <= {w_wb_tag, r_idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
                        r_MEM_Data    <= w_wb_word;
                        r_cnt         <= r_cnt + BLOCK_OFFSET_WIDTH'(1);
                    end else if (i_MEM_Data_Read) begin
                        if (i_MEM_Last) begin
                            r_state       <= S_FILL;
                            r_MEM_RW      <= 1'b1;
                            r_MEM_Address <= {r_tag, r_idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
                            r_cnt         <= '0;
                            if (r_way) r_dirty1[r_idx] <= 1'b0;
                            else       r_dirty0[r_idx] <= 1'b0;
                        end else begin
                            r_MEM_Data <= w_wb_word;
                            r_cnt      <= r_cnt + BLOCK_OFFSET_WIDTH'(1);
                        end
                    end
                end
                S_FILL: begin
                    if (i_MEM_Valid) begin
                        if (r_cnt == r_off) r_Data <= w_fill_word;
                        r_cnt <= r_cnt + BLOCK_OFFSET_WIDTH'(1);
                        if (i_MEM_Last) begin
                            r_state      <= S_READY;
                            r_Ready      <= 1'b1;
                            r_Valid      <= 1'b1;
                            r_MEM_Valid  <= 1'b0;
                            r_lru[r_idx] <= !r_way;
                            if (r_way) begin
                                r_valid1[r_idx] <= 1'b1;
                                r_dirty1[r_idx] <= r_store;
                            end else begin
                                r_valid0[r_idx] <= 1'b1;
                                r_dirty0[r_idx] <= r_store;
                            end
                        end
                    end
                end
                default: r_state <= S_READY;
            endcase
        end
    end

    assign o_Ready            = r_Ready;
    assign o_Valid            = r_Valid;
    assign o_Data             = r_Data;
    assign o_MEM_Valid        = r_MEM_Valid;
    assign o_MEM_Read_Write_n = r_MEM_RW;
    assign o_MEM_Address      = r_MEM_Address;
    assign o_MEM_Data         = r_MEM_Data;

endmodule
`default_nettype wire
